// File: rtl/add_check_pkg.sv
// Shared definitions for the add result checker.
//   state_e : checker FSM states
//   entry_t : one shift-line slot {valid, expected sum, vector index}
//   LATENCY_MIN/LATENCY_MAX : legal range of the DUT latency parameter
//   ENTRY_MAX_W : storage width of the expected/index fields; the top
//                 zero-extends its WIDTH/CNT_W values into these fields
package add_check_pkg;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 8;
  localparam int ENTRY_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic                   valid;
    logic [ENTRY_MAX_W-1:0] expected;
    logic [ENTRY_MAX_W-1:0] index;
  } entry_t;

endpackage

// File: rtl/add_check_delay.sv
// STAGES-deep shift line of checker entries.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : synchronous clear of all valid bits
//   din          : entry pushed every cycle (bubble when din.valid=0)
//   dout         : entry that entered STAGES cycles earlier
//   any_valid    : some stage currently holds a valid entry
// Only the valid bits are reset/cleared; payload bits are don't-care
// whenever their valid bit is low.
module add_check_delay
  import add_check_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   clear,
  input  entry_t din,
  output entry_t dout,
  output logic   any_valid
);

  entry_t line_q [STAGES];
  entry_t line_d [STAGES];

  always_comb begin
    line_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      line_d[i] = line_q[i-1];
    end
    if (clear) begin
      for (int i = 0; i < STAGES; i++) begin
        line_d[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      any_valid = any_valid | line_q[i].valid;
    end
  end

  assign dout = line_q[STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        line_q[i].valid <= 1'b0;
      end
    end else begin
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/add_result_checker.sv
// On-chip result checker for the WIDTH-bit adder.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start, num_vectors  : begin a run of num_vectors vectors (from IDLE/DONE)
//   in_valid, in0, in1  : operand stream shared with the adder
//   dut_out             : adder result, valid LATENCY cycles after operands
//   busy, done          : run in progress / results held
//   pass_count, fail_count : saturating compare counters
//   first_fail_*        : index, expected and actual value of first mismatch
module add_result_checker
  import add_check_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_index,
  output logic [WIDTH-1:0] first_fail_expected,
  output logic [WIDTH-1:0] first_fail_actual
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX ||
      WIDTH > ENTRY_MAX_W || CNT_W > ENTRY_MAX_W) begin : g_param_check
    $error("add_result_checker: parameter out of range");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             ff_valid_q, ff_valid_d;
  logic [CNT_W-1:0] ff_index_q, ff_index_d;
  logic [WIDTH-1:0] ff_exp_q, ff_exp_d;
  logic [WIDTH-1:0] ff_act_q, ff_act_d;

  logic   start_take;
  logic   accept;
  entry_t push_entry;
  entry_t line_out;
  logic   line_busy;
  logic   unused_line_bits;

  // Start is only honoured between runs; a same-edge in_valid is dropped.
  assign start_take = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign accept     = in_valid && (state_q == ST_RUN);

  always_comb begin
    push_entry = '0;
    if (accept) begin
      push_entry.valid              = 1'b1;
      // Carry-out dropped to match the adder's WIDTH-bit result.
      push_entry.expected[WIDTH-1:0] = in0 + in1;
      push_entry.index[CNT_W-1:0]    = acc_q;
    end
  end

  add_check_delay #(
    .STAGES(LATENCY)
  ) u_delay (
    .clock    (clock),
    .reset    (reset),
    .clear    (start_take),
    .din      (push_entry),
    .dout     (line_out),
    .any_valid(line_busy)
  );

  // Upper field bits are always zero; fold them so every bit has a reader.
  assign unused_line_bits = ^line_out;

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    acc_d      = acc_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    ff_valid_d = ff_valid_q;
    ff_index_d = ff_index_q;
    ff_exp_d   = ff_exp_q;
    ff_act_d   = ff_act_q;

    // Compare the entry leaving the shift line against the adder output.
    if (line_out.valid) begin
      if (dut_out == line_out.expected[WIDTH-1:0]) begin
        pass_d = sat_inc(pass_q);
      end else begin
        fail_d = sat_inc(fail_q);
        if (!ff_valid_q) begin
          ff_valid_d = 1'b1;
          ff_index_d = line_out.index[CNT_W-1:0];
          ff_exp_d   = line_out.expected[WIDTH-1:0];
          ff_act_d   = dut_out;
        end
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_take) begin
          num_d      = num_vectors;
          acc_d      = '0;
          pass_d     = '0;
          fail_d     = '0;
          ff_valid_d = 1'b0;
          ff_index_d = '0;
          ff_exp_d   = '0;
          ff_act_d   = '0;
          state_d    = (num_vectors == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          acc_d = acc_q + 1'b1;
          if ((acc_q + 1'b1) == num_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!line_busy) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      acc_q      <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      ff_valid_q <= 1'b0;
      ff_index_q <= '0;
      ff_exp_q   <= '0;
      ff_act_q   <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      acc_q      <= acc_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      ff_valid_q <= ff_valid_d;
      ff_index_q <= ff_index_d;
      ff_exp_q   <= ff_exp_d;
      ff_act_q   <= ff_act_d;
    end
  end

  assign busy                = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done                = (state_q == ST_DONE);
  assign pass_count          = pass_q;
  assign fail_count          = fail_q;
  assign first_fail_valid    = ff_valid_q;
  assign first_fail_index    = ff_index_q;
  assign first_fail_expected = ff_exp_q;
  assign first_fail_actual   = ff_act_q;

endmodule

// File: tb/tb_add_result_checker.sv
// Bench for add_result_checker: one checker with LATENCY=1 and one with
// LATENCY=3, each fed by a bench adder model that can be told to return 0
// for a chosen vector. Expected run results go into a queue when a run is
// started; a monitor per checker pops and compares when done rises.
module tb_add_result_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic [15:0] num_vectors = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in0 = '0;
  logic [7:0]  in1 = '0;
  logic        bad = 1'b0;

  logic [7:0]  dut_out1;
  logic [7:0]  a3 [3];
  logic        busy1, done1, ffv1, busy3, done3, ffv3;
  logic [15:0] pass1, fail1, ffidx1, pass3, fail3, ffidx3;
  logic [7:0]  ffexp1, ffact1, ffexp3, ffact3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string tag;
    int    cyc;
    int    pass;
    int    fail;
    int    ffv;
    int    ffidx;
    int    ffexp;
    int    ffact;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Adder models: registered sum, optionally corrupted to 0.
  always @(posedge clock) begin
    dut_out1 <= bad ? 8'd0 : in0 + in1;
    a3[0]    <= bad ? 8'd0 : in0 + in1;
    a3[1]    <= a3[0];
    a3[2]    <= a3[1];
  end

  add_result_checker #(.WIDTH(8), .LATENCY(1), .CNT_W(16)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .num_vectors(num_vectors),
    .in_valid(in_valid), .in0(in0), .in1(in1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .pass_count(pass1), .fail_count(fail1),
    .first_fail_valid(ffv1), .first_fail_index(ffidx1),
    .first_fail_expected(ffexp1), .first_fail_actual(ffact1)
  );

  add_result_checker #(.WIDTH(8), .LATENCY(3), .CNT_W(16)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .num_vectors(num_vectors),
    .in_valid(in_valid), .in0(in0), .in1(in1), .dut_out(a3[2]),
    .busy(busy3), .done(done3), .pass_count(pass3), .fail_count(fail3),
    .first_fail_valid(ffv3), .first_fail_index(ffidx3),
    .first_fail_expected(ffexp3), .first_fail_actual(ffact3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic f);
    in_valid = v;
    in0      = a;
    in1      = b;
    bad      = f;
    @(negedge clock);
  endtask

  // Issues start on the chosen checker and queues the expected result;
  // off is the number of edges from the start edge to done becoming visible.
  task automatic start_run(input string tag, input bit use3, input int n, input int off,
                           input int p, input int f, input int ffv, input int ffidx,
                           input int ffexp, input int ffact);
    exp_t e;
    e.tag = tag; e.cyc = cyc + 1 + off; e.pass = p; e.fail = f;
    e.ffv = ffv; e.ffidx = ffidx; e.ffexp = ffexp; e.ffact = ffact;
    if (use3) q3.push_back(e); else q1.push_back(e);
    num_vectors = 16'(n);
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input bit use3);
    for (int i = 0; i < 60; i++) begin
      if ((use3 ? q3.size() : q1.size()) == 0) return;
      @(negedge clock);
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: done never rose, pending=%0d, expected pending=0",
             tag, use3 ? q3.size() : q1.size());
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  32'(busy1),  0);
    check({tag, "_done"},  32'(done1),  0);
    check({tag, "_pass"},  32'(pass1),  0);
    check({tag, "_fail"},  32'(fail1),  0);
    check({tag, "_ffv"},   32'(ffv1),   0);
    check({tag, "_ffidx"}, 32'(ffidx1), 0);
    check({tag, "_ffexp"}, 32'(ffexp1), 0);
    check({tag, "_ffact"}, 32'(ffact1), 0);
  endtask

  // Monitors: compare final results each time done rises.
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (done1 && !prev) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL l1_unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          e = q1.pop_front();
          check({e.tag, "_done_cyc"}, 32'(cyc),    32'(e.cyc));
          check({e.tag, "_pass"},     32'(pass1),  32'(e.pass));
          check({e.tag, "_fail"},     32'(fail1),  32'(e.fail));
          check({e.tag, "_ffv"},      32'(ffv1),   32'(e.ffv));
          check({e.tag, "_ffidx"},    32'(ffidx1), 32'(e.ffidx));
          check({e.tag, "_ffexp"},    32'(ffexp1), 32'(e.ffexp));
          check({e.tag, "_ffact"},    32'(ffact1), 32'(e.ffact));
        end
      end
      prev = done1;
    end
  end

  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (done3 && !prev) begin
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL l3_unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          e = q3.pop_front();
          check({e.tag, "_done_cyc"}, 32'(cyc),    32'(e.cyc));
          check({e.tag, "_pass"},     32'(pass3),  32'(e.pass));
          check({e.tag, "_fail"},     32'(fail3),  32'(e.fail));
          check({e.tag, "_ffv"},      32'(ffv3),   32'(e.ffv));
          check({e.tag, "_ffidx"},    32'(ffidx3), 32'(e.ffidx));
        end
      end
      prev = done3;
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_zero("reset");

    // T1: N=4 correct; an in_valid coinciding with start must be dropped.
    in_valid = 1'b1; in0 = 8'd9; in1 = 8'd9;
    start_run("t1", 1'b0, 4, 6, 4, 0, 0, 0, 0, 0);
    drive(1, 8'd3, 8'd4, 0);
    drive(1, 8'd255, 8'd1, 0);
    drive(1, 8'd128, 8'd128, 0);
    drive(1, 8'd0, 8'd0, 0);
    drive(0, 8'd0, 8'd0, 0);
    wait_drain("t1", 1'b0);

    // T2: restart from DONE; vector 1 returns 0 instead of 4.
    start_run("t2", 1'b0, 3, 5, 2, 1, 1, 1, 4, 0);
    drive(1, 8'd1, 8'd1, 0);
    drive(1, 8'd2, 8'd2, 1);
    drive(1, 8'd3, 8'd3, 0);
    drive(0, 8'd0, 8'd0, 0);
    wait_drain("t2", 1'b0);

    // T3: mismatches at 0 and 2; capture stays on index 0 (30 vs 0).
    start_run("t3", 1'b0, 3, 5, 1, 2, 1, 0, 30, 0);
    drive(1, 8'd10, 8'd20, 1);
    drive(1, 8'd5, 8'd5, 0);
    drive(1, 8'd200, 8'd100, 1);
    drive(0, 8'd0, 8'd0, 0);
    wait_drain("t3", 1'b0);

    // T4: LATENCY=3, gapped valids, two extra valids after the last vector.
    start_run("t4", 1'b1, 3, 9, 3, 0, 0, 0, 0, 0);
    drive(1, 8'd11, 8'd22, 0);
    drive(0, 8'd0, 8'd0, 0);
    drive(1, 8'd250, 8'd10, 0);
    drive(0, 8'd0, 8'd0, 0);
    drive(1, 8'd7, 8'd8, 0);
    drive(1, 8'd1, 8'd1, 1);
    drive(1, 8'd2, 8'd2, 1);
    drive(0, 8'd0, 8'd0, 0);
    check("t4_busy_last_cmp", 32'(busy3), 1);
    wait_drain("t4", 1'b1);

    // T5: reset, then N=0 completes at once; then N=2 from DONE.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start_run("t5a", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    wait_drain("t5a", 1'b0);
    start_run("t5b", 1'b0, 2, 4, 2, 0, 0, 0, 0, 0);
    drive(1, 8'd100, 8'd27, 0);
    drive(1, 8'd64, 8'd200, 0);
    drive(0, 8'd0, 8'd0, 0);
    wait_drain("t5b", 1'b0);

    // T6: reset mid-run after 2 vectors (first one mismatching).
    num_vectors = 16'd4;
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    drive(1, 8'd5, 8'd6, 1);
    drive(1, 8'd1, 8'd2, 0);
    check("t6_pre_fail", 32'(fail1), 1);
    check("t6_pre_ffexp", 32'(ffexp1), 11);
    check("t6_pre_busy", 32'(busy1), 1);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check_zero("t6_reset");
    reset = 1'b0;
    start_run("t6", 1'b0, 2, 4, 2, 0, 0, 0, 0, 0);
    drive(1, 8'd40, 8'd2, 0);
    drive(1, 8'd128, 8'd127, 0);
    drive(0, 8'd0, 8'd0, 0);
    wait_drain("t6", 1'b0);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
